seg_scan_mux: RTL and testbench

- Time-multiplexes NUM_DIGITS seven-segment patterns onto one shared segment bus and a set of active-low digit anodes.
- Sits directly downstream of the per-digit BCD-to-7-segment decoders.
  - seg_in carries their 8-bit patterns: active-low, bit7=a … bit1=g, bit0=dp.
  - blank_in carries their per-digit blank flags.
- Inputs are snapshotted once per frame so a digit never tears mid-scan.
- A dead-time gap between digit slots suppresses ghosting.

---
 rtl/seg_scan_mux.sv | 93 +++++++++
 tb/tb_seg_scan_mux.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Seven-segment scan multiplexer: one shared segment bus, active-low anodes,
// a per-frame input snapshot and an optional dead-time gap at each slot start.
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [8*NUM_DIGITS-1:0]       seg_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [7:0]                    seg,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_C     = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] PH_DEAD = 1'b0;
    localparam logic [0:0] PH_ON   = 1'b1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        digit_q, digit_d;
    logic [8*NUM_DIGITS-1:0] seg_snap_q, seg_snap_d;
    logic [NUM_DIGITS-1:0]   blank_snap_q, blank_snap_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic                    frame_start_q, frame_start_d;
    logic                    snap_take;
    logic [0:0]              phase_d;

    // Phase of the cycle being entered; a zero dead time means always ON.
    if (DEAD_CYCLES == 0) begin : g_no_dead
        assign phase_d = PH_ON;
    end else begin : g_dead
        assign phase_d = (cnt_d < DEAD_C) ? PH_DEAD : PH_ON;
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        digit_d = digit_q;
        if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + 1'b1;
        end

        snap_take     = (cnt_q == '0) && (digit_q == '0);
        seg_snap_d    = snap_take ? seg_in   : seg_snap_q;
        blank_snap_d  = snap_take ? blank_in : blank_snap_q;
        frame_start_d = snap_take;

        // Outputs are computed for the next cycle so they line up with cnt/digit there.
        an_d  = '1;
        seg_d = 8'hFF;
        if ((phase_d == PH_ON) && enable && !blank_snap_d[digit_d]) begin
            an_d[digit_d] = 1'b0;
            seg_d         = seg_snap_d[{digit_d, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            digit_q       <= '0;
            seg_snap_q    <= '1;
            blank_snap_q  <= '1;
            an_q          <= '1;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            seg_snap_q    <= seg_snap_d;
            blank_snap_q  <= blank_snap_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign digit_idx   = digit_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: two instances (with and without dead time) checked
// every cycle against a cycle-indexed model built from input history.
module tb_seg_scan_mux;

    localparam int N    = 4;
    localparam int RD   = 8;
    localparam int DC   = 2;
    localparam int FP   = RD * N;
    localparam int HMAX = 4096;
    localparam logic [31:0] S0 = 32'h090B239F;
    localparam logic [31:0] S1 = 32'h090B019F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] seg_in = '1;
    logic [3:0]  blank_in = '1;
    logic [3:0]  an_a, an_b;
    logic [7:0]  seg_a, seg_b;
    logic [1:0]  idx_a, idx_b;
    logic        fs_a, fs_b;

    always #5 clk = ~clk;

    seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .seg_in(seg_in), .blank_in(blank_in),
        .an(an_a), .seg(seg_a), .digit_idx(idx_a), .frame_start(fs_a));

    seg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DEAD_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .seg_in(seg_in), .blank_in(blank_in),
        .an(an_b), .seg(seg_b), .digit_idx(idx_b), .frame_start(fs_b));

    int checks = 0;
    int failures = 0;
    int t = 0;
    bit prev_rst = 1'b0;
    bit seen_rst = 1'b0;
    bit known = 1'b0;
    logic [31:0] seg_h [HMAX];
    logic [3:0]  blank_h [HMAX];
    bit          en_h [HMAX];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    // Cycle t counts from the first cycle after reset deasserts. The display in
    // cycle t reflects the frame snapshot taken at the latest frame start <= t-1
    // and the enable level seen in cycle t-1.
    function automatic void model(input int tt, input int dead, output logic [3:0] a,
                                  output logic [7:0] sg, output int idx, output logic fs);
        int s;
        a  = 4'hF;
        sg = 8'hFF;
        idx = 0;
        fs = 1'b0;
        if (tt == 0) return;
        idx = (tt / RD) % N;
        fs  = ((tt - 1) % FP) == 0;
        s   = ((tt - 1) / FP) * FP;
        if ((tt % RD) >= dead && en_h[tt-1] && !blank_h[s][idx]) begin
            a[idx] = 1'b0;
            sg     = seg_h[s][8*idx +: 8];
        end
    endfunction

    always @(negedge clk) begin
        logic [3:0] ea;
        logic [7:0] es;
        int ei;
        logic ef;
        if (known && t < HMAX) begin
            model(t, DC, ea, es, ei, ef);
            chk("an_a", 32'(an_a), 32'(ea));
            chk("seg_a", 32'(seg_a), 32'(es));
            chk("idx_a", 32'(idx_a), 32'(ei));
            chk("fs_a", 32'(fs_a), 32'(ef));
            model(t, 0, ea, es, ei, ef);
            chk("an_b", 32'(an_b), 32'(ea));
            chk("seg_b", 32'(seg_b), 32'(es));
            chk("idx_b", 32'(idx_b), 32'(ei));
            chk("fs_b", 32'(fs_b), 32'(ef));
            chk("one_anode_a", 32'($countones(~an_a) <= 1), 32'd1);
            chk("one_anode_b", 32'($countones(~an_b) <= 1), 32'd1);
        end
    end

    task automatic step(input bit r, input bit en, input logic [31:0] s, input logic [3:0] b);
        @(posedge clk);
        #1;
        if (prev_rst) t = 0;
        else t = t + 1;
        reset    = r;
        enable   = en;
        seg_in   = s;
        blank_in = b;
        if (t < HMAX) begin
            seg_h[t]   = s;
            blank_h[t] = b;
            en_h[t]    = en;
        end
        known    = seen_rst;
        seen_rst = seen_rst | r;
        prev_rst = r;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rs;
        logic [3:0]  rb;

        // Scan sequence and snapshot isolation
        repeat (3) step(1'b1, 1'b1, S0, 4'h0);
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1, (i >= 12) ? S1 : S0, 4'h0);
            if (i == 0)  begin chk("rst_an", 32'(an_a), 32'hF); chk("rst_seg", 32'(seg_a), 32'hFF); end
            if (i == 1)  chk("fs_c1", 32'(fs_a), 32'd1);
            if (i == 2)  begin chk("d0_an", 32'(an_a), 32'hE); chk("d0_seg", 32'(seg_a), 32'h9F); end
            if (i == 4)  chk("fs_c4", 32'(fs_a), 32'd0);
            if (i == 8)  chk("dead_an", 32'(an_a), 32'hF);
            if (i == 10) begin chk("d1_an", 32'(an_a), 32'hD); chk("d1_seg", 32'(seg_a), 32'h23); end
            if (i == 14) chk("iso_seg", 32'(seg_a), 32'h23);
            if (i == 18) chk("d2_an", 32'(an_a), 32'hB);
            if (i == 26) begin chk("d3_an", 32'(an_a), 32'h7); chk("d3_seg", 32'(seg_a), 32'h09); end
            if (i == 32) begin chk("wrap_an", 32'(an_a), 32'hF); chk("wrap_idx", 32'(idx_a), 32'd0); end
            if (i == 33) chk("fs_c33", 32'(fs_a), 32'd1);
            if (i == 42) begin chk("new_an", 32'(an_a), 32'hD); chk("new_seg", 32'(seg_a), 32'h01); end
            if (i == 7)  chk("nd_an7", 32'(an_b), 32'hE);
            if (i == 8)  chk("nd_an8", 32'(an_b), 32'hD);
        end

        // Enable drop
        step(1'b1, 1'b1, S0, 4'h0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, !(i >= 4 && i <= 13), S0, 4'h0);
            if (i == 3)  chk("en_pre_an", 32'(an_a), 32'hE);
            if (i == 5)  begin chk("en_off_an", 32'(an_a), 32'hF); chk("en_off_seg", 32'(seg_a), 32'hFF); end
            if (i == 10) chk("en_idx", 32'(idx_a), 32'd1);
            if (i == 14) chk("en_off_an14", 32'(an_a), 32'hF);
            if (i == 15) chk("en_back_an", 32'(an_a), 32'hD);
        end

        // Blanking digit 3
        step(1'b1, 1'b1, S0, 4'h8);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, S0, 4'h8);
            if (i == 20) chk("blk_d2_an", 32'(an_a), 32'hB);
            if (i == 28) begin chk("blk_an", 32'(an_a), 32'hF); chk("blk_seg", 32'(seg_a), 32'hFF); end
        end

        // Mid-operation reset during digit 2 ON
        step(1'b1, 1'b1, S0, 4'h0);
        for (int i = 0; i < 40; i++) begin
            step(i == 20, 1'b1, S0, 4'h0);
            if (i == 20) chk("mr_pre_an", 32'(an_a), 32'hB);
            if (i == 21) begin
                chk("mr_an", 32'(an_a), 32'hF);
                chk("mr_seg", 32'(seg_a), 32'hFF);
                chk("mr_idx", 32'(idx_a), 32'd0);
            end
            if (i == 23) begin chk("mr_d0_an", 32'(an_a), 32'hE); chk("mr_d0_seg", 32'(seg_a), 32'h9F); end
        end

        // Randomized traffic
        rs = $urandom;
        rb = 4'h0;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 3) == 0) rs = $urandom;
            if ($urandom_range(0, 19) == 0) rb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, rs, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
